screen_draw_sequencer: RTL and testbench
========================================

Name: screen_draw_sequencer

Overview:
- Upstream controller for the full-screen background drawer.
- Tracks which screen the game shows (START, MAP1, MAP2, GG) from game events and drives the drawer's ScreenSelect/drawScreenEnable.
- Waits for drawScreenDone and pulses screen_ready so sprite/animation stages draw only over a finished background.
- Starts draws on frame-tick boundaries, and only when the screen has changed (dirty).

Parameters:
- FRAME_DIV, 833333, clock cycles per frame tick (50 MHz / 60 Hz).
- DRAW_TIMEOUT, 20000, max cycles in WAIT_DONE before abort (19200 pixels plus margin); used only with the optional feature.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start_pressed  in  1  level; START->MAP1, GG->START
- map_advance  in  1  level; MAP1->MAP2
- player_dead  in  1  level; MAP1/MAP2->GG
- drawScreenDone  in  1  drawer completion flag
- ScreenSelect  out  2  00 MAP1, 01 MAP2, 10 START, 11 GG
- drawScreenEnable  out  1  held high for the whole draw
- frame_tick  out  1  one-cycle pulse every FRAME_DIV cycles
- screen_ready  out  1  one-cycle pulse when a draw completes
- busy  out  1  high in REQ and WAIT_DONE
- timeout_err  out  1  sticky abort flag (optional feature only; otherwise tied 0)

Behaviour:
- Clocking/reset: one clock, posedge. Reset is asynchronous, active-low (resetn) and clears all registers.
- Reset values:
  - ScreenSelect=2'b10 (START), cur_screen=START, dirty=1.
  - drawScreenEnable=0, frame_tick=0, screen_ready=0, busy=0, timeout_err=0.
  - Frame counter=0, FSM=IDLE.
- Frame counter: 0..FRAME_DIV-1, wraps to 0. frame_tick=1 in the cycle after the counter holds FRAME_DIV-1. The counter runs in every state.
- Screen transitions:
  - Evaluated every cycle, regardless of FSM state.
  - Priority when simultaneous: player_dead > map_advance > start_pressed.
  - Legal transitions: START+start_pressed->MAP1; MAP1+map_advance->MAP2; MAP1/MAP2+player_dead->GG; GG+start_pressed->START.
  - Illegal events are ignored. A legal change updates cur_screen and sets dirty.
- ScreenSelect is a registered copy of cur_screen, loaded only on the IDLE->REQ transition. It stays stable during a draw even if cur_screen changes.
- FSM:
  - IDLE: if frame_tick && dirty -> REQ. Load ScreenSelect, clear dirty.
  - REQ (1 cycle): drawScreenEnable=1 -> WAIT_DONE.
  - WAIT_DONE: drawScreenEnable=1. On drawScreenDone=1 -> DONE.
  - DONE (1 cycle): drawScreenEnable=0, screen_ready=1 -> IDLE.
- busy=1 in REQ and WAIT_DONE.
- Latency: from frame_tick to drawScreenEnable rising is 1 cycle (REQ is registered). From drawScreenDone to enable falling is 1 cycle.
- Change during a draw: dirty is set again, so the new screen draws at the first frame_tick after returning to IDLE. The current draw is never aborted.
- frame_tick while not in IDLE is ignored; the draw waits for the next tick.
- drawScreenDone outside WAIT_DONE is ignored.
- Reset asserted mid-draw: enable drops immediately (async). After release, START is redrawn on the first tick.

Optional Feature:
- Macro: DRAW_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT_DONE.
  - On reaching DRAW_TIMEOUT without drawScreenDone: go to DONE without pulsing screen_ready, set timeout_err (sticky until reset), set dirty so the screen retries on the next tick.
- Undefined: no watchdog, WAIT_DONE waits forever, timeout_err tied 0.

Decomposition:
- Package screen_pkg:
  - Screen encodings SCR_MAP1=2'b00, SCR_MAP2=2'b01, SCR_START=2'b10, SCR_GG=2'b11.
  - FSM state encodings IDLE/REQ/WAIT_DONE/DONE.
  - Pixel count constant 19200.
- One sub-module: frame_tick_gen (parameter FRAME_DIV; ports clock, resetn, frame_tick).

Test Plan (FRAME_DIV=100, DRAW_TIMEOUT=50):
- Reset release, drawer model returns done 20 cycles after enable -> ScreenSelect=10, enable rises 1 cycle after the first frame_tick (cycle 101), exactly one screen_ready pulse, no redraw on later ticks.
- start_pressed 1 cycle in START -> next tick draws ScreenSelect=00. Then map_advance -> 01. Then player_dead -> 11. Then start_pressed -> 10.
- player_dead and map_advance in the same cycle in MAP1 -> cur_screen=GG. map_advance in START -> ignored, no draw.
- start_pressed during WAIT_DONE of START -> ScreenSelect stays 10 until done. Next tick draws 00.
- Reset asserted mid-WAIT_DONE -> enable=0 same cycle. After release, ScreenSelect=10 and a redraw on the first tick.
- DRAW_TIMEOUT_EN defined, drawer never returns done -> enable drops after 50 cycles, timeout_err=1, no screen_ready, retry on next tick.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared encodings for the screen draw sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package screen_pkg;

  // Screen codes as seen by the background drawer on ScreenSelect
  typedef enum logic [1:0] {
    SCR_MAP1  = 2'b00,
    SCR_MAP2  = 2'b01,
    SCR_START = 2'b10,
    SCR_GG    = 2'b11
  } screen_e;

  // Draw handshake sequencer states
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    REQ       = 2'b01,
    WAIT_DONE = 2'b10,
    DONE      = 2'b11
  } draw_state_e;

  // Pixels in one full-screen background (160 x 120)
  localparam int PIXEL_COUNT = 19200;

endpackage : screen_pkg

// File: rtl/frame_tick_gen.sv
// Free-running frame divider producing a one-cycle frame_tick every FRAME_DIV cycles.
// Latency: frame_tick is registered, high the cycle after the counter holds FRAME_DIV-1.
// Backpressure: none; runs unconditionally out of reset.
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clock,
  input  logic resetn,
  output logic frame_tick
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] frame_cnt;

  // Count 0..FRAME_DIV-1 and flag the wrap one cycle later
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (frame_cnt == LAST);
      if (frame_cnt == LAST) begin
        frame_cnt <= '0;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule : frame_tick_gen

// File: rtl/screen_draw_sequencer.sv
// Tracks the current game screen and sequences full-screen background draws on frame ticks.
// Latency: frame_tick -> drawScreenEnable 1 cycle; drawScreenDone -> enable low + screen_ready 1 cycle.
// Backpressure: waits indefinitely for drawScreenDone (DRAW_TIMEOUT_EN adds an abort watchdog).
module screen_draw_sequencer
  import screen_pkg::*;
#(
  parameter int FRAME_DIV    = 833333,
  parameter int DRAW_TIMEOUT = PIXEL_COUNT + 800
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start_pressed,
  input  logic       map_advance,
  input  logic       player_dead,
  input  logic       drawScreenDone,
  output logic [1:0] ScreenSelect,
  output logic       drawScreenEnable,
  output logic       frame_tick,
  output logic       screen_ready,
  output logic       busy,
  output logic       timeout_err
);

  // Degenerate dividers/timeouts would make the tick or watchdog meaningless
  if (FRAME_DIV < 2) begin : g_bad_frame_div
    $error("FRAME_DIV must be at least 2");
  end
  if (DRAW_TIMEOUT < 2) begin : g_bad_draw_timeout
    $error("DRAW_TIMEOUT must be at least 2");
  end

  screen_e     cur_screen;
  screen_e     next_screen;
  logic        screen_change;
  logic        dirty;
  draw_state_e state;

  frame_tick_gen #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_tick_gen (
    .clock      (clock),
    .resetn     (resetn),
    .frame_tick (frame_tick)
  );

  // Game-event screen transitions; player_dead outranks map_advance in MAP1
  always_comb begin
    next_screen = cur_screen;
    case (cur_screen)
      SCR_START: if (start_pressed) next_screen = SCR_MAP1;
      SCR_MAP1: begin
        if (player_dead) begin
          next_screen = SCR_GG;
        end else if (map_advance) begin
          next_screen = SCR_MAP2;
        end
      end
      SCR_MAP2:  if (player_dead) next_screen = SCR_GG;
      SCR_GG:    if (start_pressed) next_screen = SCR_START;
    endcase
    screen_change = (next_screen != cur_screen);
  end

`ifdef DRAW_TIMEOUT_EN
  localparam int WD_W = $clog2(DRAW_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DRAW_TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // Screen tracking, dirty flag and draw handshake FSM with registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cur_screen       <= SCR_START;
      dirty            <= 1'b1;
      state            <= IDLE;
      ScreenSelect     <= SCR_START;
      drawScreenEnable <= 1'b0;
      screen_ready     <= 1'b0;
      busy             <= 1'b0;
`ifdef DRAW_TIMEOUT_EN
      wd_cnt           <= '0;
      timeout_err      <= 1'b0;
`endif
    end else begin
      cur_screen   <= next_screen;
      screen_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Ticks are only honoured here; a tick during a draw is dropped
          if (frame_tick && dirty) begin
            state            <= REQ;
            ScreenSelect     <= cur_screen;
            drawScreenEnable <= 1'b1;
            busy             <= 1'b1;
            dirty            <= 1'b0;
          end
        end
        REQ: begin
          state <= WAIT_DONE;
`ifdef DRAW_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        WAIT_DONE: begin
          if (drawScreenDone) begin
            state            <= DONE;
            drawScreenEnable <= 1'b0;
            busy             <= 1'b0;
            screen_ready     <= 1'b1;
`ifdef DRAW_TIMEOUT_EN
          end else if (wd_cnt == WD_LAST) begin
            // Abort silently and retry the same screen on a later tick
            state            <= DONE;
            drawScreenEnable <= 1'b0;
            busy             <= 1'b0;
            timeout_err      <= 1'b1;
            dirty            <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
      // A screen change always wins over the IDLE clear so it is never lost
      if (screen_change) begin
        dirty <= 1'b1;
      end
    end
  end

`ifndef DRAW_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

endmodule : screen_draw_sequencer

// File: tb/tb_screen_draw_sequencer.sv
// Directed bench for screen_draw_sequencer with a small drawer model.
// Latency: n/a.
// Backpressure: drawer returns done 20 cycles after enable unless drawer_auto is cleared.
module tb_screen_draw_sequencer;

  logic       clock;
  logic       resetn;
  logic       start_pressed;
  logic       map_advance;
  logic       player_dead;
  logic       drawScreenDone;
  logic [1:0] ScreenSelect;
  logic       drawScreenEnable;
  logic       frame_tick;
  logic       screen_ready;
  logic       busy;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state (sampled on the falling edge)
  int         cyc      = 0;
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  int         ready_cnt = 0;
  int         ready_cyc = 0;
  int         tick_cyc  = -1;
  logic [1:0] last_sel  = 2'b00;
  logic       en_q      = 1'b0;

  // Drawer model state
  logic drawer_auto = 1'b1;
  int   dcnt        = 0;

  screen_draw_sequencer #(
    .FRAME_DIV    (100),
    .DRAW_TIMEOUT (50)
  ) dut (
    .clock            (clock),
    .resetn           (resetn),
    .start_pressed    (start_pressed),
    .map_advance      (map_advance),
    .player_dead      (player_dead),
    .drawScreenDone   (drawScreenDone),
    .ScreenSelect     (ScreenSelect),
    .drawScreenEnable (drawScreenEnable),
    .frame_tick       (frame_tick),
    .screen_ready     (screen_ready),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle-stamped event monitor
  always @(negedge clock) begin
    if (!resetn) begin
      cyc      = 0;
      tick_cyc = -1;
    end else begin
      cyc++;
    end
    if (frame_tick && tick_cyc < 0) tick_cyc = cyc;
    if (screen_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
    if (drawScreenEnable && !en_q) begin
      rise_cnt++;
      rise_cyc = cyc;
      last_sel = ScreenSelect;
    end
    en_q = drawScreenEnable;
  end

  // Drawer: raises done for one cycle on the 20th enabled cycle
  initial begin
    drawScreenDone = 1'b0;
    forever begin
      @(negedge clock);
      if (drawer_auto && drawScreenEnable) begin
        dcnt++;
        drawScreenDone = (dcnt == 20);
      end else begin
        dcnt = 0;
        drawScreenDone = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse(input logic s, input logic m, input logic d);
    start_pressed = s;
    map_advance   = m;
    player_dead   = d;
    step();
    start_pressed = 1'b0;
    map_advance   = 1'b0;
    player_dead   = 1'b0;
  endtask

  task automatic wait_rise(input string tag, input int budget);
    int r0;
    int n;
    r0 = rise_cnt;
    n  = 0;
    while (rise_cnt == r0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, int'(rise_cnt != r0), 1);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int r0;
    int n;
    r0 = ready_cnt;
    n  = 0;
    while (ready_cnt == r0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, int'(ready_cnt != r0), 1);
  endtask

  task automatic draw_expect(input string tag, input logic [1:0] sel);
    wait_rise({tag, "_rise"}, 300);
    chk({tag, "_sel"}, int'(last_sel), int'(sel));
    wait_ready({tag, "_ready"}, 100);
  endtask

  initial begin
    int r0;
    int q0;
    int n;
    int fall_cyc;
    resetn        = 1'b0;
    start_pressed = 1'b0;
    map_advance   = 1'b0;
    player_dead   = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_sel",     int'(ScreenSelect), 2);
    chk("rst_en",      int'(drawScreenEnable), 0);
    chk("rst_tick",    int'(frame_tick), 0);
    chk("rst_ready",   int'(screen_ready), 0);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    resetn = 1'b1;

    // First draw after reset: START at tick+1
    wait_rise("boot_rise", 300);
    chk("boot_tick_cyc", tick_cyc, 100);
    chk("boot_rise_cyc", rise_cyc, 101);
    chk("boot_sel",      int'(last_sel), 2);
    chk("boot_busy",     int'(busy), 1);
    wait_ready("boot_ready", 100);
    chk("boot_ready_cyc", ready_cyc, 121);
    chk("boot_en_fall",   int'(drawScreenEnable), 0);
    r0 = rise_cnt;
    q0 = ready_cnt;
    repeat (250) step();
    chk("boot_no_redraw", rise_cnt, r0);
    chk("boot_one_ready", ready_cnt, q0);

    // Full screen cycle START->MAP1->MAP2->GG->START
    pulse(1, 0, 0);
    draw_expect("seq_map1", 2'b00);
    pulse(0, 1, 0);
    draw_expect("seq_map2", 2'b01);
    pulse(0, 0, 1);
    draw_expect("seq_gg", 2'b11);
    pulse(1, 0, 0);
    draw_expect("seq_start", 2'b10);

    // Priority: dead beats advance in MAP1; advance ignored in START
    pulse(1, 0, 0);
    draw_expect("pri_map1", 2'b00);
    pulse(0, 1, 1);
    draw_expect("pri_gg", 2'b11);
    pulse(1, 0, 0);
    draw_expect("pri_start", 2'b10);
    pulse(0, 1, 0);
    r0 = rise_cnt;
    repeat (250) step();
    chk("ign_adv_start", rise_cnt, r0);

    // Screen change during a START draw keeps ScreenSelect stable
    pulse(1, 0, 0);
    draw_expect("mid_map1", 2'b00);
    pulse(0, 0, 1);
    draw_expect("mid_gg", 2'b11);
    pulse(1, 0, 0);
    wait_rise("mid_start_rise", 300);
    chk("mid_start_sel", int'(last_sel), 2);
    repeat (5) step();
    pulse(1, 0, 0);
    repeat (4) step();
    chk("mid_sel_hold", int'(ScreenSelect), 2);
    chk("mid_en_hold",  int'(drawScreenEnable), 1);
    wait_ready("mid_start_ready", 100);
    chk("mid_sel_after", int'(ScreenSelect), 2);
    wait_rise("mid_next_rise", 300);
    chk("mid_next_sel", int'(last_sel), 0);

    // Asynchronous reset in the middle of the MAP1 draw
    repeat (5) step();
    #2 resetn = 1'b0;
    #1;
    chk("arst_en",   int'(drawScreenEnable), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_sel",  int'(ScreenSelect), 2);
    step();
    resetn = 1'b1;
    wait_rise("arst_rise", 300);
    chk("arst_rise_cyc", rise_cyc, 101);
    chk("arst_redraw_sel", int'(last_sel), 2);
    wait_ready("arst_ready", 100);

`ifdef DRAW_TIMEOUT_EN
    // Drawer stalls: watchdog aborts, flags error, retries next tick
    drawer_auto = 1'b0;
    q0 = ready_cnt;
    pulse(1, 0, 0);
    wait_rise("to_rise", 300);
    n = 0;
    while (drawScreenEnable && n < 200) begin
      step();
      n++;
    end
    fall_cyc = cyc;
    chk("to_en_fell",   int'(drawScreenEnable), 0);
    chk("to_en_len",    fall_cyc - rise_cyc, 51);
    chk("to_err",       int'(timeout_err), 1);
    chk("to_no_ready",  ready_cnt, q0);
    wait_rise("to_retry_rise", 300);
    chk("to_retry_sel", int'(last_sel), 0);
    drawer_auto = 1'b1;
    wait_ready("to_retry_ready", 100);
    chk("to_err_sticky", int'(timeout_err), 1);
`else
    fall_cyc = 0;
    n = 0;
    chk("no_timeout_err", int'(timeout_err) + fall_cyc + n, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_screen_draw_sequencer
